// File: rtl/ddr3_cmd_decoder.sv
// ddr3_cmd_decoder
// Samples the DDR3 command/address pins on every rising clk1 edge and turns
// each sample into a command event. It also captures MR0..MR3, follows the
// power-up init sequence and keeps the open-row state of each bank, flagging
// protocol violations on a separate error pulse.
//
// Optional feature: define DDR_TIMING_CHECK_EN to build the per-bank tRCD/tRP
// down-counters. Without it no counters exist and error codes 4/5 never occur.
//
// Init FSM:
//   state         | meaning
//   ST_INIT_RESET | cke held low; waiting for the first cke=1 sample
//   ST_INIT_MR    | collecting MRS to MR0..MR3 in any order
//   ST_INIT_ZQ    | all MRs seen; waiting for ZQCL (addr[10]=1)
//   ST_READY      | normal operation, bank tracking active

module ddr3_cmd_decoder #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 16,
  parameter int T_RCD     = 11,
  parameter int T_RP      = 11
) (
  input  logic                              clk1,
  input  logic                              rst_n,
  input  logic                              cke,
  input  logic                              cs_n,
  input  logic                              ras_n,
  input  logic                              cas_n,
  input  logic                              we_n,
  input  logic [BA_BITS-1:0]                ba,
  input  logic [ADDR_BITS-1:0]              addr,
  output logic                              o_cmd_valid,
  output logic [3:0]                        o_cmd_code,
  output logic [BA_BITS-1:0]                o_cmd_bank,
  output logic [ADDR_BITS-1:0]              o_cmd_addr,
  output logic [15:0]                       o_mr0,
  output logic [15:0]                       o_mr1,
  output logic [15:0]                       o_mr2,
  output logic [15:0]                       o_mr3,
  output logic [(2**BA_BITS)-1:0]           o_bank_open,
  output logic [(2**BA_BITS)*ADDR_BITS-1:0] o_open_row,
  output logic                              o_init_done,
  output logic                              o_err_valid,
  output logic [2:0]                        o_err_code
);

  localparam int NBANK = 2**BA_BITS;

  localparam logic [3:0] CMD_MRS      = 4'd0;
  localparam logic [3:0] CMD_REF      = 4'd1;
  localparam logic [3:0] CMD_PRE      = 4'd2;
  localparam logic [3:0] CMD_ACT      = 4'd3;
  localparam logic [3:0] CMD_WR       = 4'd4;
  localparam logic [3:0] CMD_RD       = 4'd5;
  localparam logic [3:0] CMD_ZQ       = 4'd6;
  localparam logic [3:0] CMD_NOP      = 4'd7;
  localparam logic [3:0] CMD_CKE_LOW  = 4'd8;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
  localparam logic [2:0] ERR_RW_CLOSED= 3'd2;
  localparam logic [2:0] ERR_PRE_INIT = 3'd3;
`ifdef DDR_TIMING_CHECK_EN
  localparam logic [2:0] ERR_TRCD     = 3'd4;
  localparam logic [2:0] ERR_TRP      = 3'd5;
  localparam int CNT_W = $clog2(((T_RCD > T_RP) ? T_RCD : T_RP) + 1);
`endif

  typedef enum logic [1:0] {
    ST_INIT_RESET = 2'd0,
    ST_INIT_MR    = 2'd1,
    ST_INIT_ZQ    = 2'd2,
    ST_READY      = 2'd3
  } init_state_t;

  init_state_t                            state;
  logic [3:0]                             mr_seen;
  logic [3:0]                             mr_bit;
  logic [3:0]                             dec_code;
  logic [2:0]                             err_code_n;
  logic                                   in_ready;
  logic [3:0][15:0]                       mr_q;
  logic [NBANK-1:0]                       bank_open_q;
  logic [NBANK-1:0][ADDR_BITS-1:0]        row_q;
`ifdef DDR_TIMING_CHECK_EN
  logic [NBANK-1:0][CNT_W-1:0]            cnt_q;
`endif

  assign in_ready = (state == ST_READY);
  assign mr_bit   = 4'b0001 << ba[1:0];

  // Pin decode; with cs_n low the {ras_n,cas_n,we_n} value is the command code.
  always_comb begin
    dec_code = CMD_NOP;
    if (!cke)
      dec_code = CMD_CKE_LOW;
    else if (!cs_n)
      dec_code = {1'b0, ras_n, cas_n, we_n};
  end

  // Protocol checks; ordering of the if-chains gives lowest code priority.
  always_comb begin
    err_code_n = ERR_NONE;
    case (dec_code)
      CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD: begin
        if (!in_ready) begin
          err_code_n = ERR_PRE_INIT;
        end else if (dec_code == CMD_ACT) begin
          if (bank_open_q[ba])
            err_code_n = ERR_ACT_OPEN;
`ifdef DDR_TIMING_CHECK_EN
          // A closed bank's counter can only have been loaded by a PRE.
          else if (cnt_q[ba] != '0)
            err_code_n = ERR_TRP;
`endif
        end else if (dec_code == CMD_WR || dec_code == CMD_RD) begin
          if (!bank_open_q[ba])
            err_code_n = ERR_RW_CLOSED;
`ifdef DDR_TIMING_CHECK_EN
          // An open bank's counter can only have been loaded by its ACT.
          else if (cnt_q[ba] != '0)
            err_code_n = ERR_TRCD;
`endif
        end
      end
      default: err_code_n = ERR_NONE;
    endcase
  end

  // Init sequencing FSM with registered init_done.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state       <= ST_INIT_RESET;
      mr_seen     <= 4'h0;
      o_init_done <= 1'b0;
    end else if (dec_code == CMD_CKE_LOW) begin
      state       <= ST_INIT_RESET;
      mr_seen     <= 4'h0;
      o_init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT_RESET: begin
          state   <= ST_INIT_MR;
          mr_seen <= 4'h0;
        end
        ST_INIT_MR: begin
          if (dec_code == CMD_MRS) begin
            mr_seen <= mr_seen | mr_bit;
            if ((mr_seen | mr_bit) == 4'hF)
              state <= ST_INIT_ZQ;
          end
        end
        ST_INIT_ZQ: begin
          if (dec_code == CMD_ZQ && addr[10]) begin
            state       <= ST_READY;
            o_init_done <= 1'b1;
          end
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Registered command and error event outputs; command fields hold on NOP.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      o_cmd_valid <= 1'b0;
      o_cmd_code  <= CMD_NOP;
      o_cmd_bank  <= '0;
      o_cmd_addr  <= '0;
      o_err_valid <= 1'b0;
      o_err_code  <= ERR_NONE;
    end else begin
      o_cmd_valid <= (dec_code != CMD_NOP);
      if (dec_code != CMD_NOP) begin
        o_cmd_code <= dec_code;
        o_cmd_bank <= ba;
        o_cmd_addr <= addr;
      end
      o_err_valid <= (err_code_n != ERR_NONE);
      o_err_code  <= err_code_n;
    end
  end

  // Mode register capture; MRS is honoured in every state.
  always_ff @(posedge clk1) begin
    if (!rst_n)
      mr_q <= '0;
    else if (dec_code == CMD_MRS)
      mr_q[ba[1:0]] <= 16'(addr);
  end

  // Per-bank open/row tracking, only while READY.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      bank_open_q <= '0;
      row_q       <= '0;
    end else if (in_ready) begin
      if (dec_code == CMD_ACT) begin
        bank_open_q[ba] <= 1'b1;
        row_q[ba]       <= addr;
      end else if (dec_code == CMD_PRE) begin
        if (addr[10])
          bank_open_q <= '0;
        else
          bank_open_q[ba] <= 1'b0;
      end
    end
  end

`ifdef DDR_TIMING_CHECK_EN
  // Saturating tRCD/tRP down-counters; loads mirror the bank tracking above.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (in_ready && dec_code == CMD_ACT && ba == BA_BITS'(b))
          cnt_q[b] <= CNT_W'(T_RCD - 1);
        else if (in_ready && dec_code == CMD_PRE && (addr[10] || ba == BA_BITS'(b)))
          cnt_q[b] <= CNT_W'(T_RP - 1);
        else if (cnt_q[b] != '0)
          cnt_q[b] <= cnt_q[b] - CNT_W'(1);
      end
    end
  end
`endif

  assign o_mr0       = mr_q[0];
  assign o_mr1       = mr_q[1];
  assign o_mr2       = mr_q[2];
  assign o_mr3       = mr_q[3];
  assign o_bank_open = bank_open_q;
  assign o_open_row  = row_q;

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Randomized + directed bench for ddr3_cmd_decoder. A cycle-stamped reference
// model (last ACT/PRE time per bank, seen-MR set, init phase) predicts every
// registered output after each clk1 edge.

module tb_ddr3_cmd_decoder;

  localparam int BA_BITS   = 3;
  localparam int ADDR_BITS = 16;
  localparam int NBANK     = 8;
  localparam int T_RCD     = 11;
  localparam int T_RP      = 11;
`ifdef DDR_TIMING_CHECK_EN
  localparam bit TCHK = 1'b1;
`else
  localparam bit TCHK = 1'b0;
`endif

  localparam int C_MRS = 0, C_REF = 1, C_PRE = 2, C_ACT = 3, C_WR = 4, C_RD = 5, C_ZQ = 6;

  logic                    clk1 = 1'b0;
  logic                    rst_n, cke, cs_n, ras_n, cas_n, we_n;
  logic [BA_BITS-1:0]      ba;
  logic [ADDR_BITS-1:0]    addr;
  logic                    o_cmd_valid;
  logic [3:0]              o_cmd_code;
  logic [BA_BITS-1:0]      o_cmd_bank;
  logic [ADDR_BITS-1:0]    o_cmd_addr;
  logic [15:0]             o_mr0, o_mr1, o_mr2, o_mr3;
  logic [NBANK-1:0]        o_bank_open;
  logic [NBANK*ADDR_BITS-1:0] o_open_row;
  logic                    o_init_done;
  logic                    o_err_valid;
  logic [2:0]              o_err_code;

  ddr3_cmd_decoder #(
    .BA_BITS(BA_BITS), .ADDR_BITS(ADDR_BITS), .T_RCD(T_RCD), .T_RP(T_RP)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr),
    .o_cmd_valid(o_cmd_valid), .o_cmd_code(o_cmd_code), .o_cmd_bank(o_cmd_bank),
    .o_cmd_addr(o_cmd_addr), .o_mr0(o_mr0), .o_mr1(o_mr1), .o_mr2(o_mr2),
    .o_mr3(o_mr3), .o_bank_open(o_bank_open), .o_open_row(o_open_row),
    .o_init_done(o_init_done), .o_err_valid(o_err_valid), .o_err_code(o_err_code)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          cyc;
  int          m_phase;
  bit [3:0]    m_seen;
  logic [15:0] m_mr   [4];
  bit          m_open [NBANK];
  logic [15:0] m_row  [NBANK];
  int          m_last [NBANK];
  bit          m_last_act [NBANK];
  // predicted outputs
  logic        e_valid;
  logic [3:0]  e_code;
  logic [2:0]  e_bank;
  logic [15:0] e_addr;
  logic        e_err_valid;
  logic [2:0]  e_err_code;
  logic        e_done;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_seen = 4'h0;
    for (int i = 0; i < 4; i++) m_mr[i] = 16'h0;
    for (int i = 0; i < NBANK; i++) begin
      m_open[i] = 1'b0; m_row[i] = 16'h0; m_last[i] = -1000; m_last_act[i] = 1'b0;
    end
    e_valid = 1'b0; e_code = 4'd7; e_bank = 3'd0; e_addr = 16'h0;
    e_err_valid = 1'b0; e_err_code = 3'd0; e_done = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit k, input bit cs, input bit r,
                            input bit c, input bit w, input logic [2:0] b,
                            input logic [15:0] a);
    int kind;
    int err;
    bit ready;
    cyc++;
    if (!rst) begin
      model_reset();
      return;
    end
    kind  = !k ? 8 : (cs ? 7 : (int'(r) * 4 + int'(c) * 2 + int'(w)));
    ready = (m_phase == 3);
    err   = 0;
    if (kind == C_MRS) m_mr[b[1:0]] = a;
    if (!ready && kind >= 1 && kind <= 5) begin
      err = 3;
    end else if (ready) begin
      if (kind == C_ACT) begin
        if (m_open[b]) err = 1;
        else if (TCHK && !m_last_act[b] && (cyc - m_last[b]) < T_RP) err = 5;
        m_open[b] = 1'b1; m_row[b] = a; m_last[b] = cyc; m_last_act[b] = 1'b1;
      end else if (kind == C_WR || kind == C_RD) begin
        if (!m_open[b]) err = 2;
        else if (TCHK && m_last_act[b] && (cyc - m_last[b]) < T_RCD) err = 4;
      end else if (kind == C_PRE) begin
        for (int i = 0; i < NBANK; i++)
          if (a[10] || i == int'(b)) begin
            m_open[i] = 1'b0; m_last[i] = cyc; m_last_act[i] = 1'b0;
          end
      end
    end
    if (kind == 8) begin
      m_phase = 0; m_seen = 4'h0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_seen = 4'h0;
    end else if (m_phase == 1) begin
      if (kind == C_MRS) begin
        m_seen[b[1:0]] = 1'b1;
        if (m_seen == 4'hF) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (kind == C_ZQ && a[10]) m_phase = 3;
    end
    e_done  = (m_phase == 3);
    e_valid = (kind != 7);
    if (kind != 7) begin
      e_code = 4'(kind); e_bank = b; e_addr = a;
    end
    e_err_valid = (err != 0);
    e_err_code  = 3'(err);
  endtask

  task automatic compare_all();
    logic [NBANK-1:0]         eo;
    logic [NBANK*16-1:0]      er;
    for (int i = 0; i < NBANK; i++) begin
      eo[i] = m_open[i];
      er[i*16 +: 16] = m_row[i];
    end
    chk("cmd_valid", 128'(o_cmd_valid), 128'(e_valid));
    chk("cmd_code",  128'(o_cmd_code),  128'(e_code));
    chk("cmd_bank",  128'(o_cmd_bank),  128'(e_bank));
    chk("cmd_addr",  128'(o_cmd_addr),  128'(e_addr));
    chk("err_valid", 128'(o_err_valid), 128'(e_err_valid));
    if (e_err_valid) chk("err_code", 128'(o_err_code), 128'(e_err_code));
    chk("init_done", 128'(o_init_done), 128'(e_done));
    chk("bank_open", 128'(o_bank_open), 128'(eo));
    chk("open_row",  128'(o_open_row),  128'(er));
    chk("mr0", 128'(o_mr0), 128'(m_mr[0]));
    chk("mr1", 128'(o_mr1), 128'(m_mr[1]));
    chk("mr2", 128'(o_mr2), 128'(m_mr[2]));
    chk("mr3", 128'(o_mr3), 128'(m_mr[3]));
  endtask

  task automatic drive(input bit rst, input bit k, input bit cs, input bit r,
                       input bit c, input bit w, input logic [2:0] b,
                       input logic [15:0] a);
    rst_n = rst; cke = k; cs_n = cs; ras_n = r; cas_n = c; we_n = w; ba = b; addr = a;
    model_step(rst, k, cs, r, c, w, b, a);
    @(posedge clk1);
    #1;
    compare_all();
  endtask

  task automatic cmd(input int code, input logic [2:0] b, input logic [15:0] a);
    logic [2:0] cc;
    cc = 3'(code);
    drive(1'b1, 1'b1, 1'b0, cc[2], cc[1], cc[0], b, a);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 16'($urandom));
  endtask

  task automatic quick_init();
    int order [4];
    int j, t;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
    nop(1);
    for (int i = 0; i < 4; i++) order[i] = i;
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 4; i++) cmd(C_MRS, 3'(order[i]), 16'($urandom));
    cmd(C_ZQ, 3'd0, 16'h0400);
  endtask

  initial begin
    int r;
    int pick;
    cyc = 0;
    model_reset();
    rst_n = 1'b0; cke = 1'b0; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = '0; addr = '0;

    // reset values
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 16'hFFFF);
    chk("reset_code", 128'(o_cmd_code), 128'd7);

    // init sequence with a pre-init ACT
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
    nop(1);
    cmd(C_MRS, 3'd2, 16'h0008);
    cmd(C_MRS, 3'd3, 16'h0000);
    cmd(C_ACT, 3'd1, 16'h0055);
    chk("preinit_code", 128'(o_err_code), 128'd3);
    chk("preinit_open", 128'(o_bank_open), 128'd0);
    cmd(C_MRS, 3'd1, 16'h0000);
    cmd(C_MRS, 3'd0, 16'h1D70);
    chk("done_before_zq", 128'(o_init_done), 128'd0);
    cmd(C_ZQ, 3'd0, 16'h0400);
    chk("init_mr0", 128'(o_mr0), 128'h1D70);
    chk("init_mr2", 128'(o_mr2), 128'h0008);
    chk("init_done", 128'(o_init_done), 128'd1);

    // bank tracking
    cmd(C_ACT, 3'd5, 16'h1234);
    nop(12);
    cmd(C_ACT, 3'd5, 16'h0042);
    chk("act_open_code", 128'(o_err_code), 128'd1);
    chk("row5", 128'(o_open_row[5*16 +: 16]), 128'h0042);

    // close-all then access
    cmd(C_ACT, 3'd0, 16'h0100);
    cmd(C_ACT, 3'd3, 16'h0300);
    nop(12);
    chk("three_open", 128'(o_bank_open), 128'h29);
    cmd(C_PRE, 3'd0, 16'h0400);
    chk("pre_all", 128'(o_bank_open), 128'd0);
    cmd(C_RD, 3'd3, 16'h0000);
    chk("rd_closed_code", 128'(o_err_code), 128'd2);

`ifdef DDR_TIMING_CHECK_EN
    nop(12);
    cmd(C_ACT, 3'd2, 16'h0077);
    nop(9);
    cmd(C_WR, 3'd2, 16'h0000);
    chk("trcd_10_code", 128'(o_err_code), 128'd4);
    cmd(C_PRE, 3'd2, 16'h0000);
    nop(9);
    cmd(C_ACT, 3'd2, 16'h0078);
    chk("trp_10_code", 128'(o_err_code), 128'd5);
    nop(10);
    cmd(C_WR, 3'd2, 16'h0010);
    chk("trcd_11_err", 128'(o_err_valid), 128'd0);
    chk("trcd_11_cmd", 128'(o_cmd_code), 128'd4);
`else
    cmd(C_ACT, 3'd2, 16'h0077);
    cmd(C_WR, 3'd2, 16'h0000);
    chk("no_timing_err", 128'(o_err_valid), 128'd0);
`endif

    // reset mid-operation
    cmd(C_ACT, 3'd6, 16'h0099);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
    chk("midrst_open", 128'(o_bank_open), 128'd0);
    chk("midrst_mr0", 128'(o_mr0), 128'd0);
    chk("midrst_done", 128'(o_init_done), 128'd0);

    // randomized traffic
    for (int round = 0; round < 6; round++) begin
      quick_init();
      for (int n = 0; n < 300; n++) begin
        r = $urandom_range(0, 199);
        if (r < 1) begin
          drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
        end else if (r < 4) begin
          drive(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom), 16'($urandom));
        end else if (r < 90) begin
          nop(1);
        end else begin
          pick = $urandom_range(0, 9);
          case (pick)
            0, 1, 2: cmd(C_ACT, 3'($urandom), 16'($urandom));
            3, 4:    cmd(C_PRE, 3'($urandom), 16'($urandom));
            5:       cmd(C_WR,  3'($urandom), 16'($urandom));
            6:       cmd(C_RD,  3'($urandom), 16'($urandom));
            7:       cmd(C_REF, 3'($urandom), 16'($urandom));
            8:       cmd(C_ZQ,  3'($urandom), 16'($urandom));
            default: cmd(C_MRS, 3'($urandom), 16'($urandom));
          endcase
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
